// File: rtl/pid_sh_sequencer_if.sv
// Signal bundle between the register bank / sample path and the S&H sequencer.
// Samples and config are continuous levels (no valid/ready): every clk_i edge consumes the current values.
interface pid_sh_sequencer_if #(
  parameter int DW = 14,
  parameter int CW = 16
);
  logic [DW-1:0] trig_i;
  logic [DW-1:0] meas_i;
  logic          cfg_en_i;
  logic [DW-1:0] cfg_thr_hi_i;
  logic [DW-1:0] cfg_thr_lo_i;
  logic [CW-1:0] cfg_debounce_i;
  logic [CW-1:0] cfg_settle_i;
  logic [DW-1:0] cfg_sp_i;
  logic [DW-2:0] cfg_step_i;
  logic          cnt_clr_i;
  logic [DW-1:0] sp_o;
  logic          pid_hold_o;
  logic          int_rst_o;
  logic [2:0]    state_o;
  logic [15:0]   hold_cnt_o;

  modport master (
    output trig_i, meas_i, cfg_en_i, cfg_thr_hi_i, cfg_thr_lo_i, cfg_debounce_i,
           cfg_settle_i, cfg_sp_i, cfg_step_i, cnt_clr_i,
    input  sp_o, pid_hold_o, int_rst_o, state_o, hold_cnt_o
  );

  modport slave (
    input  trig_i, meas_i, cfg_en_i, cfg_thr_hi_i, cfg_thr_lo_i, cfg_debounce_i,
           cfg_settle_i, cfg_sp_i, cfg_step_i, cnt_clr_i,
    output sp_o, pid_hold_o, int_rst_o, state_o, hold_cnt_o
  );
endinterface

// File: rtl/pid_sh_sequencer.sv
// Sample-and-hold sequencer: freezes the PID while the trigger is active, then settles,
// resets the integrator and ramps the setpoint from the measurement back to the target.
module pid_sh_sequencer #(
  parameter int DW = 14,
  parameter int CW = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  pid_sh_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HOLD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RAMP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [DW-1:0] sp_q;
  logic          hold_q;
  logic          int_rst_q;
  logic [15:0]   hold_cnt_q;
  logic [CW-1:0] dcnt_q;
  logic [CW-1:0] scnt_q;

  logic          above;
  logic          below;
  logic          exit_cond;
  logic [CW:0]   deb_need;
  logic [CW:0]   dcnt_inc;
  logic          fire;
  logic [CW-1:0] dcnt_next;
  logic          hold_inc;

  logic [DW:0]   sp_ext;
  logic [DW:0]   diff;
  logic [DW:0]   abs_diff;
  logic [DW:0]   step_ext;
  logic [DW:0]   ramp_sum;
  logic          ramp_done;

  assign above = $signed(bus.trig_i) >= $signed(bus.cfg_thr_hi_i);
  assign below = $signed(bus.trig_i) <  $signed(bus.cfg_thr_lo_i);

  always_comb begin
    exit_cond = 1'b0;
    case (state_q)
      ST_RUN, ST_SETTLE, ST_RAMP: exit_cond = above;
      ST_HOLD:                    exit_cond = below;
      default:                    exit_cond = 1'b0;
    endcase
  end

  // A debounce of 0 behaves like 1; the +1 is done one bit wider so it never wraps.
  assign deb_need  = (bus.cfg_debounce_i == '0) ? (CW+1)'(1) : {1'b0, bus.cfg_debounce_i};
  assign dcnt_inc  = {1'b0, dcnt_q} + (CW+1)'(1);
  assign fire      = exit_cond && (dcnt_inc >= deb_need);
  assign dcnt_next = exit_cond ? dcnt_inc[CW-1:0] : '0;
  assign hold_inc  = bus.cfg_en_i && fire && ((state_q == ST_RUN) || (state_q == ST_RAMP));

  // Ramp arithmetic in DW+1 bits; the clamp keeps the truncated result in range.
  assign sp_ext    = {sp_q[DW-1], sp_q};
  assign diff      = {bus.cfg_sp_i[DW-1], bus.cfg_sp_i} - sp_ext;
  assign abs_diff  = diff[DW] ? (~diff + (DW+1)'(1)) : diff;
  assign step_ext  = {2'b00, bus.cfg_step_i};
  assign ramp_done = (bus.cfg_step_i == '0) || (abs_diff <= step_ext);
  assign ramp_sum  = diff[DW] ? (sp_ext - step_ext) : (sp_ext + step_ext);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sp_q       <= '0;
      hold_q     <= 1'b0;
      int_rst_q  <= 1'b1;
      hold_cnt_q <= '0;
      dcnt_q     <= '0;
      scnt_q     <= '0;
    end else begin
      if (bus.cnt_clr_i) begin
        hold_cnt_q <= '0;
      end else if (hold_inc && (hold_cnt_q != 16'hFFFF)) begin
        hold_cnt_q <= hold_cnt_q + 16'd1;
      end

      if (!bus.cfg_en_i) begin
        state_q   <= ST_IDLE;
        sp_q      <= bus.cfg_sp_i;
        hold_q    <= 1'b0;
        int_rst_q <= 1'b1;
        dcnt_q    <= '0;
        scnt_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_RUN;
            sp_q      <= bus.cfg_sp_i;
            hold_q    <= 1'b0;
            int_rst_q <= 1'b0;
            dcnt_q    <= '0;
          end
          ST_RUN: begin
            sp_q      <= bus.cfg_sp_i;
            hold_q    <= 1'b0;
            int_rst_q <= 1'b0;
            if (fire) begin
              state_q <= ST_HOLD;
              hold_q  <= 1'b1;
              dcnt_q  <= '0;
            end else begin
              dcnt_q  <= dcnt_next;
            end
          end
          ST_HOLD: begin
            hold_q    <= 1'b1;
            int_rst_q <= 1'b0;
            if (fire) begin
              state_q <= ST_SETTLE;
              scnt_q  <= bus.cfg_settle_i;
              dcnt_q  <= '0;
            end else begin
              dcnt_q  <= dcnt_next;
            end
          end
          ST_SETTLE: begin
            // Re-trigger wins over settle completion.
            if (fire) begin
              state_q <= ST_HOLD;
              dcnt_q  <= '0;
            end else if (scnt_q == '0) begin
              state_q   <= ST_RAMP;
              sp_q      <= bus.meas_i;
              hold_q    <= 1'b0;
              int_rst_q <= 1'b1;
              dcnt_q    <= '0;
            end else begin
              scnt_q  <= scnt_q - CW'(1);
              dcnt_q  <= dcnt_next;
            end
          end
          ST_RAMP: begin
            hold_q    <= 1'b0;
            int_rst_q <= 1'b0;
            if (fire) begin
              state_q <= ST_HOLD;
              hold_q  <= 1'b1;
              dcnt_q  <= '0;
            end else if (ramp_done) begin
              state_q <= ST_RUN;
              sp_q    <= bus.cfg_sp_i;
              dcnt_q  <= '0;
            end else begin
              sp_q    <= ramp_sum[DW-1:0];
              dcnt_q  <= dcnt_next;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sp_o       = sp_q;
  assign bus.pid_hold_o = hold_q;
  assign bus.int_rst_o  = int_rst_q;
  assign bus.state_o    = state_q;
  assign bus.hold_cnt_o = hold_cnt_q;

endmodule

// File: tb/tb_pid_sh_sequencer.sv
// Directed bench for pid_sh_sequencer: a table of per-cycle vectors with hand-computed
// expected outputs, followed by hand-written async-reset and counter-saturation sequences.
module tb_pid_sh_sequencer;

  localparam int DW = 14;
  localparam int CW = 16;
  localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_SETTLE = 3, S_RAMP = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pid_sh_sequencer_if #(.DW(DW), .CW(CW)) bus ();

  pid_sh_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit en;
    bit clr;
    int trig;
    int meas;
    int sp;
    int step;
    int settle;
    int deb;
    int e_state;
    int e_sp;
    int e_hold;
    int e_int;
    int e_cnt;
  } vec_t;

  vec_t tbl[$];

  bit g_en, g_clr;
  int g_meas, g_sp, g_step, g_settle, g_deb;

  task automatic add(input int trig, input int e_state, input int e_sp,
                     input int e_hold, input int e_int, input int e_cnt);
    vec_t v;
    v.en = g_en; v.clr = g_clr; v.trig = trig; v.meas = g_meas; v.sp = g_sp;
    v.step = g_step; v.settle = g_settle; v.deb = g_deb;
    v.e_state = e_state; v.e_sp = e_sp; v.e_hold = e_hold; v.e_int = e_int; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    bus.cfg_en_i       = v.en;
    bus.cnt_clr_i      = v.clr;
    bus.trig_i         = 14'(v.trig);
    bus.meas_i         = 14'(v.meas);
    bus.cfg_sp_i       = 14'(v.sp);
    bus.cfg_step_i     = 13'(v.step);
    bus.cfg_settle_i   = 16'(v.settle);
    bus.cfg_debounce_i = 16'(v.deb);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int idx,
                     input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input int e_state, input int e_sp,
                            input int e_hold, input int e_int, input int e_cnt);
    logic signed [31:0] sp_act;
    sp_act = 32'($signed(bus.sp_o));
    chk("state", idx, 32'(bus.state_o), e_state);
    chk("sp", idx, sp_act, e_sp);
    chk("pid_hold", idx, 32'(bus.pid_hold_o), e_hold);
    chk("int_rst", idx, 32'(bus.int_rst_o), e_int);
    chk("hold_cnt", idx, 32'(bus.hold_cnt_o), e_cnt);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cfg_thr_hi_i = 14'd750;
    bus.cfg_thr_lo_i = 14'd500;
    g_en = 1'b0; g_clr = 1'b0; g_meas = 0; g_sp = 1000; g_step = 100; g_settle = 10; g_deb = 3;
    begin
      vec_t v0;
      v0.en = 1'b0; v0.clr = 1'b0; v0.trig = 0; v0.meas = 0; v0.sp = 1000; v0.step = 100;
      v0.settle = 10; v0.deb = 3;
      drive(v0);
    end
    tick();
    check_outs(-1, S_IDLE, 0, 0, 1, 0);
    rst = 1'b0;

    // Power-up, debounce miss, then HOLD after 3 qualifying samples
    g_en = 1'b1;
    add(0,   S_RUN, 1000, 0, 0, 0);
    add(800, S_RUN, 1000, 0, 0, 0);
    add(800, S_RUN, 1000, 0, 0, 0);
    add(0,   S_RUN, 1000, 0, 0, 0);
    add(800, S_RUN, 1000, 0, 0, 0);
    add(800, S_RUN, 1000, 0, 0, 0);
    add(800, S_HOLD, 1000, 1, 0, 1);
    add(800, S_HOLD, 1000, 1, 0, 1);
    // Release, 11 cycles of SETTLE, integrator pulse, ramp 200 -> 1000
    g_meas = 200;
    add(400, S_HOLD, 1000, 1, 0, 1);
    add(400, S_HOLD, 1000, 1, 0, 1);
    add(400, S_SETTLE, 1000, 1, 0, 1);
    for (int k = 0; k < 10; k++) add(400, S_SETTLE, 1000, 1, 0, 1);
    add(400, S_RAMP, 200, 0, 1, 1);
    for (int v = 300; v <= 900; v += 100) add(400, S_RAMP, v, 0, 0, 1);
    add(400, S_RUN, 1000, 0, 0, 1);

    // Clamp: ramp from 950 lands on 1000 with no overshoot
    g_meas = 950; g_settle = 0;
    add(800, S_RUN, 1000, 0, 0, 1);
    add(800, S_RUN, 1000, 0, 0, 1);
    add(800, S_HOLD, 1000, 1, 0, 2);
    add(400, S_HOLD, 1000, 1, 0, 2);
    add(400, S_HOLD, 1000, 1, 0, 2);
    add(400, S_SETTLE, 1000, 1, 0, 2);
    add(400, S_RAMP, 950, 0, 1, 2);
    add(400, S_RUN, 1000, 0, 0, 2);

    // Full-scale ramp -8192 -> 8191 with step 8191: -1, then clamped path without wrap
    g_sp = 8191; g_step = 8191; g_meas = -8192;
    add(800, S_RUN, 8191, 0, 0, 2);
    add(800, S_RUN, 8191, 0, 0, 2);
    add(800, S_HOLD, 8191, 1, 0, 3);
    add(400, S_HOLD, 8191, 1, 0, 3);
    add(400, S_HOLD, 8191, 1, 0, 3);
    add(400, S_SETTLE, 8191, 1, 0, 3);
    add(400, S_RAMP, -8192, 0, 1, 3);
    add(400, S_RAMP, -1, 0, 0, 3);
    add(400, S_RAMP, 8190, 0, 0, 3);
    add(400, S_RUN, 8191, 0, 0, 3);

    // Re-trigger during SETTLE returns to HOLD without counting and without pulse
    g_sp = 1000; g_step = 100; g_settle = 10; g_meas = 200;
    add(800, S_RUN, 1000, 0, 0, 3);
    add(800, S_RUN, 1000, 0, 0, 3);
    add(800, S_HOLD, 1000, 1, 0, 4);
    add(400, S_HOLD, 1000, 1, 0, 4);
    add(400, S_HOLD, 1000, 1, 0, 4);
    add(400, S_SETTLE, 1000, 1, 0, 4);
    add(800, S_SETTLE, 1000, 1, 0, 4);
    add(800, S_SETTLE, 1000, 1, 0, 4);
    add(800, S_HOLD, 1000, 1, 0, 4);
    add(800, S_HOLD, 1000, 1, 0, 4);

    // Re-trigger during RAMP counts a new HOLD entry and freezes sp
    g_settle = 0;
    add(400, S_HOLD, 1000, 1, 0, 4);
    add(400, S_HOLD, 1000, 1, 0, 4);
    add(400, S_SETTLE, 1000, 1, 0, 4);
    add(0,   S_RAMP, 200, 0, 1, 4);
    add(800, S_RAMP, 300, 0, 0, 4);
    add(800, S_RAMP, 400, 0, 0, 4);
    add(800, S_HOLD, 400, 1, 0, 5);

    // Disable during RAMP -> IDLE next edge
    add(400, S_HOLD, 400, 1, 0, 5);
    add(400, S_HOLD, 400, 1, 0, 5);
    add(400, S_SETTLE, 400, 1, 0, 5);
    add(0,   S_RAMP, 200, 0, 1, 5);
    g_en = 1'b0;
    add(0, S_IDLE, 1000, 0, 1, 5);
    add(0, S_IDLE, 1000, 0, 1, 5);
    g_en = 1'b1;
    add(0, S_RUN, 1000, 0, 0, 5);

    // Clear coinciding with a HOLD entry gives 0
    add(800, S_RUN, 1000, 0, 0, 5);
    add(800, S_RUN, 1000, 0, 0, 5);
    g_clr = 1'b1;
    add(800, S_HOLD, 1000, 1, 0, 0);
    g_clr = 1'b0;

    // Debounce of 0 acts as 1
    g_deb = 0;
    add(400, S_SETTLE, 1000, 1, 0, 0);
    add(400, S_RAMP, 200, 0, 1, 0);
    add(800, S_HOLD, 200, 1, 0, 1);

    // Target changes during RAMP: downward ramp toward the new target
    g_deb = 3;
    add(400, S_HOLD, 200, 1, 0, 1);
    add(400, S_HOLD, 200, 1, 0, 1);
    add(400, S_SETTLE, 200, 1, 0, 1);
    add(400, S_RAMP, 200, 0, 1, 1);
    g_sp = -300;
    add(400, S_RAMP, 100, 0, 0, 1);
    add(400, S_RAMP, 0, 0, 0, 1);
    add(400, S_RAMP, -100, 0, 0, 1);
    add(400, S_RAMP, -200, 0, 0, 1);
    add(400, S_RUN, -300, 0, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      check_outs(i, tbl[i].e_state, tbl[i].e_sp, tbl[i].e_hold, tbl[i].e_int, tbl[i].e_cnt);
    end

    // Asynchronous reset in the middle of SETTLE
    bus.cfg_sp_i = 14'd1000;
    bus.trig_i = 14'd800;
    repeat (3) tick();
    chk("pre_rst_hold", 1000, 32'(bus.state_o), S_HOLD);
    bus.trig_i = 14'd400;
    bus.cfg_settle_i = 16'd10;
    repeat (4) tick();
    chk("pre_rst_settle", 1001, 32'(bus.state_o), S_SETTLE);
    #2;
    rst = 1'b1;
    #1;
    check_outs(1002, S_IDLE, 0, 0, 1, 0);
    #1;
    rst = 1'b0;
    bus.trig_i = 14'd0;
    tick();
    check_outs(1003, S_RUN, 1000, 0, 0, 0);

    // Hold counter saturation from a preset near full scale
    force dut.hold_cnt_q = 16'hFFFE;
    #1;
    release dut.hold_cnt_q;
    bus.trig_i = 14'd800;
    repeat (3) tick();
    check_outs(1004, S_HOLD, 1000, 1, 0, 16'hFFFF);
    bus.trig_i = 14'd400;
    bus.cfg_settle_i = 16'd0;
    bus.meas_i = 14'd200;
    repeat (3) tick();
    chk("sat_settle", 1005, 32'(bus.state_o), S_SETTLE);
    bus.trig_i = 14'd0;
    tick();
    check_outs(1006, S_RAMP, 200, 0, 1, 16'hFFFF);
    bus.trig_i = 14'd800;
    repeat (3) tick();
    check_outs(1007, S_HOLD, 400, 1, 0, 16'hFFFF);
    bus.cnt_clr_i = 1'b1;
    tick();
    bus.cnt_clr_i = 1'b0;
    chk("clr_after_sat", 1008, 32'(bus.hold_cnt_o), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
